// File: rtl/lsu_align_pipe.sv
// rtl/lsu_align_pipe.sv - MEM-stage load/store unit with alignment check and cache handshake
//
// Purpose:
//   Accepts one memory op per in_valid/in_ready handshake, flags misaligned
//   or illegal ops, issues an aligned request with byte-lane mask and
//   lane-shifted store data to the data cache, lane-aligns and extends the
//   load data, and holds the result until WB takes it. A kill abandons the
//   op; an already-issued request is drained before the next op is taken.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   kill                      pipeline flush
//   in_valid/in_ready         op handshake; in_addr, in_wdata, in_ctrl
//   dc_req_valid/dc_req_ready cache request; dc_addr, dc_wen, dc_wmask, dc_wdata
//   dc_resp_valid, dc_rdata   cache response (one per request)
//   out_valid/out_ready       result handshake; out_data, out_exc

module lsu_align_pipe #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                kill,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [3:0]          in_ctrl,
  output logic                dc_req_valid,
  input  logic                dc_req_ready,
  output logic [ADDR_W-1:0]   dc_addr,
  output logic                dc_wen,
  output logic [XLEN/8-1:0]   dc_wmask,
  output logic [XLEN-1:0]     dc_wdata,
  input  logic                dc_resp_valid,
  input  logic [XLEN-1:0]     dc_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [1:0]          out_exc
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Access size as log2(bytes): 0 byte, 1 half, 2 word, 3 double.
  function automatic logic [1:0] op_size(input logic [3:0] c);
    case (c)
      4'd1, 4'd8:        op_size = 2'd3;
      4'd2, 4'd5, 4'd9:  op_size = 2'd2;
      4'd3, 4'd6, 4'd10: op_size = 2'd1;
      default:           op_size = 2'd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Decode of the op being offered (used only at accept time)
  // ---------------------------------------------------------------------
  logic            acc;
  logic            in_illegal;
  logic            in_mis;
  logic            in_store;
  logic            in_go;
  logic [1:0]      in_exc;
  logic [OFFW-1:0] in_off;

  assign in_off   = in_addr[OFFW-1:0];
  assign in_store = (in_ctrl >= 4'd8) && (in_ctrl <= 4'd11);

  always_comb begin
    in_illegal = (in_ctrl >= 4'd12) ||
                 ((XLEN == 32) && ((in_ctrl == 4'd1) || (in_ctrl == 4'd5) || (in_ctrl == 4'd8)));
    case (op_size(in_ctrl))
      2'd3:    in_mis = (in_off != '0);
      2'd2:    in_mis = (in_off[1:0] != 2'b00);
      2'd1:    in_mis = in_off[0];
      default: in_mis = 1'b0;
    endcase
    if (in_illegal)  in_exc = 2'd3;
    else if (in_mis) in_exc = in_store ? 2'd2 : 2'd1;
    else             in_exc = 2'd0;
    in_go = (in_exc == 2'd0) && (in_ctrl != 4'd0);
  end

  assign in_ready = (state == S_IDLE) && !kill && !rst;
  assign acc      = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Registered op and result
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_ctrl;
  logic [1:0]        r_exc;
  logic [XLEN-1:0]   r_data;

  logic [OFFW-1:0]   off;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic              r_load;
  logic              r_store;
  logic [NB-1:0]     mask_base;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ext;
  logic              resp_take;

  assign off     = r_addr[OFFW-1:0];
  assign r_size  = op_size(r_ctrl);
  assign r_sgn   = (r_ctrl == 4'd2) || (r_ctrl == 4'd3) || (r_ctrl == 4'd4);
  assign r_load  = (r_ctrl >= 4'd1) && (r_ctrl <= 4'd7);
  assign r_store = (r_ctrl >= 4'd8) && (r_ctrl <= 4'd11);

  always_comb begin
    mask_base = '0;
    for (int i = 0; i < NB; i++) begin
      mask_base[i] = (i < (1 << r_size));
    end
  end

  assign sh = dc_rdata >> {off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    ext = r_sgn ? XLEN'($signed(sh[7:0]))  : XLEN'(sh[7:0]);
      2'd1:    ext = r_sgn ? XLEN'($signed(sh[15:0])) : XLEN'(sh[15:0]);
      2'd2:    ext = r_sgn ? XLEN'($signed(sh[31:0])) : XLEN'(sh[31:0]);
      default: ext = sh;
    endcase
  end

  // A response is consumed only on the path that produces a result; a
  // response seen under kill is discarded by the FSM instead.
  assign resp_take = !kill && dc_resp_valid &&
                     (((state == S_REQ) && dc_req_ready) || (state == S_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_ctrl  <= '0;
      r_exc   <= '0;
      r_data  <= '0;
    end else if (acc) begin
      r_addr  <= in_addr;
      r_wdata <= in_wdata;
      r_ctrl  <= in_ctrl;
      r_exc   <= in_exc;
      r_data  <= '0;
    end else if (resp_take) begin
      r_data  <= r_load ? ext : '0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state. Kill outranks every other event; a request that has
  // been handed to the cache must have its response drained, unless that
  // response arrives in the very cycle of the kill.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (acc) state_nxt = in_go ? S_REQ : S_DONE;
      end
      S_REQ: begin
        if (kill) begin
          if (dc_req_ready) state_nxt = dc_resp_valid ? S_IDLE : S_DRAIN;
          else              state_nxt = S_IDLE;
        end else if (dc_req_ready) begin
          state_nxt = dc_resp_valid ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (kill)               state_nxt = dc_resp_valid ? S_IDLE : S_DRAIN;
        else if (dc_resp_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (kill || out_ready) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (dc_resp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything is forced low while rst is high.
  always_comb begin
    dc_req_valid = 1'b0;
    dc_addr      = '0;
    dc_wen       = 1'b0;
    dc_wmask     = '0;
    dc_wdata     = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_exc      = '0;
    if (!rst) begin
      dc_req_valid = (state == S_REQ);
      dc_addr      = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
      dc_wen       = r_store;
      dc_wmask     = r_store ? (mask_base << off) : '0;
      dc_wdata     = r_wdata << {off, 3'b000};
      out_valid    = (state == S_DONE) && !kill;
      out_data     = r_data;
      out_exc      = r_exc;
    end
  end

endmodule

// File: tb/tb_lsu_align_pipe.sv
// tb/tb_lsu_align_pipe.sv - directed self-checking bench for lsu_align_pipe

module tb_lsu_align_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // 64-bit instance
  logic        rst, kill, in_valid, in_ready;
  logic [63:0] in_addr, in_wdata;
  logic [3:0]  in_ctrl;
  logic        dc_req_valid, dc_req_ready, dc_wen, dc_resp_valid;
  logic [63:0] dc_addr, dc_wdata, dc_rdata;
  logic [7:0]  dc_wmask;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_exc;

  lsu_align_pipe #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_ctrl(in_ctrl),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_addr(dc_addr),
    .dc_wen(dc_wen), .dc_wmask(dc_wmask), .dc_wdata(dc_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
  );

  // 32-bit instance
  logic        s_rst, s_kill, s_in_valid, s_in_ready;
  logic [31:0] s_in_addr, s_in_wdata;
  logic [3:0]  s_in_ctrl;
  logic        s_dc_req_valid, s_dc_req_ready, s_dc_wen, s_dc_resp_valid;
  logic [31:0] s_dc_addr, s_dc_wdata, s_dc_rdata;
  logic [3:0]  s_dc_wmask;
  logic        s_out_valid, s_out_ready;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_exc;

  lsu_align_pipe #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(s_rst), .kill(s_kill),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_addr(s_in_addr),
    .in_wdata(s_in_wdata), .in_ctrl(s_in_ctrl),
    .dc_req_valid(s_dc_req_valid), .dc_req_ready(s_dc_req_ready), .dc_addr(s_dc_addr),
    .dc_wen(s_dc_wen), .dc_wmask(s_dc_wmask), .dc_wdata(s_dc_wdata),
    .dc_resp_valid(s_dc_resp_valid), .dc_rdata(s_dc_rdata),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_exc(s_out_exc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; kill = 1'b0; in_valid = 1'b1; in_addr = 64'h10; in_wdata = '0; in_ctrl = 4'd2;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_rdata = '0; out_ready = 1'b0;
    s_rst = 1'b1; s_kill = 1'b0; s_in_valid = 1'b0; s_in_addr = '0; s_in_wdata = '0; s_in_ctrl = '0;
    s_dc_req_ready = 1'b0; s_dc_resp_valid = 1'b0; s_dc_rdata = '0; s_out_ready = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0 || dc_req_valid !== 1'b0) $display("FAIL reset_valids got %b%b exp 00", out_valid, dc_req_valid); else passed++;
    total++; if (out_data !== 64'h0 || out_exc !== 2'd0 || dc_addr !== 64'h0) $display("FAIL reset_data got %h %h %h exp 0", out_data, out_exc, dc_addr); else passed++;
    rst = 1'b0; s_rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_lw();
    in_valid = 1'b1; in_ctrl = 4'd2; in_addr = 64'h8000_0004;
    tick(); in_valid = 1'b0; #1;
    total++; if (dc_req_valid !== 1'b1 || dc_addr !== 64'h8000_0000 || dc_wen !== 1'b0) $display("FAIL lw_req got %b %h %b exp 1 80000000 0", dc_req_valid, dc_addr, dc_wen); else passed++;
    dc_req_ready = 1'b1;
    tick(); dc_req_ready = 1'b0; #1;
    total++; if (dc_req_valid !== 1'b0 || out_valid !== 1'b0) $display("FAIL lw_wait got %b %b exp 0 0", dc_req_valid, out_valid); else passed++;
    dc_resp_valid = 1'b1; dc_rdata = 64'h8765_4321_0000_0000;
    tick(); dc_resp_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_8765_4321 || out_exc !== 2'd0) $display("FAIL lw_result got %b %h %h exp 1 ffffffff87654321 0", out_valid, out_data, out_exc); else passed++;
    out_ready = 1'b1;
    tick(); out_ready = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL lw_release got %b %b exp 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_sb();
    in_valid = 1'b1; in_ctrl = 4'd11; in_addr = 64'h1003; in_wdata = 64'hAB;
    tick(); in_valid = 1'b0; #1;
    total++; if (dc_wmask !== 8'h08 || dc_wdata !== 64'h0000_0000_AB00_0000 || dc_wen !== 1'b1 || dc_addr !== 64'h1000) $display("FAIL sb_lanes got %h %h %b %h exp 08 ab000000 1 1000", dc_wmask, dc_wdata, dc_wen, dc_addr); else passed++;
    dc_req_ready = 1'b1; dc_resp_valid = 1'b1;
    tick(); dc_req_ready = 1'b0; dc_resp_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'h0 || out_exc !== 2'd0) $display("FAIL sb_result got %b %h %h exp 1 0 0", out_valid, out_data, out_exc); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    // SH at offset 6 lands in the top two lanes
    in_valid = 1'b1; in_ctrl = 4'd10; in_addr = 64'h1006; in_wdata = 64'hFFFF_FFFF_FFFF_1234;
    tick(); in_valid = 1'b0; #1;
    total++; if (dc_wmask !== 8'hC0 || dc_wdata !== 64'h1234_0000_0000_0000) $display("FAIL sh_lanes got %h %h exp c0 1234000000000000", dc_wmask, dc_wdata); else passed++;
    dc_req_ready = 1'b1; dc_resp_valid = 1'b1; tick(); dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_exceptions();
    logic [3:0]  ctrls [4] = '{4'd3, 4'd8, 4'd12, 4'd0};
    logic [63:0] addrs [4] = '{64'h1001, 64'h1004, 64'h1000, 64'h1000};
    logic [1:0]  excs  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_ctrl = ctrls[i]; in_addr = addrs[i]; in_wdata = 64'h55;
      tick(); in_valid = 1'b0; #1;
      total++; if (out_valid !== 1'b1 || dc_req_valid !== 1'b0 || out_exc !== excs[i] || out_data !== 64'h0) $display("FAIL exc_%0d got %b %b %h %h exp 1 0 %h 0", i, out_valid, dc_req_valid, out_exc, out_data, excs[i]); else passed++;
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_ctrl = 4'd1; in_addr = 64'h2000;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (dc_req_valid !== 1'b1 || dc_addr !== 64'h2000 || in_ready !== 1'b0) $display("FAIL stall_req_%0d got %b %h %b exp 1 2000 0", i, dc_req_valid, dc_addr, in_ready); else passed++;
      tick();
    end
    dc_req_ready = 1'b1; tick(); dc_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (dc_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL stall_wait_%0d got %b %b %b exp 0 0 0", i, dc_req_valid, out_valid, in_ready); else passed++;
      tick();
    end
    dc_resp_valid = 1'b1; dc_rdata = 64'h1122_3344_5566_7788;
    tick(); dc_resp_valid = 1'b0; dc_rdata = 64'hDEAD_BEEF_DEAD_BEEF; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== 64'h1122_3344_5566_7788 || in_ready !== 1'b0) $display("FAIL stall_hold_%0d got %b %h %b exp 1 1122334455667788 0", i, out_valid, out_data, in_ready); else passed++;
      tick();
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL stall_no_accept got %b exp 0", in_ready); else passed++;
    tick(); out_ready = 1'b0; in_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL stall_idle got %b %b exp 1 0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_kill();
    // kill in REQ before the cache accepted: straight back to IDLE
    in_valid = 1'b1; in_ctrl = 4'd2; in_addr = 64'h5000;
    tick(); in_valid = 1'b0; kill = 1'b1;
    tick(); kill = 1'b0; #1;
    total++; if (dc_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL kill_req got %b %b %b exp 0 0 1", dc_req_valid, out_valid, in_ready); else passed++;
    // kill in WAIT: drain the response, then run a new op
    in_valid = 1'b1; in_ctrl = 4'd2; in_addr = 64'h3000;
    tick(); dc_req_ready = 1'b1;
    tick(); dc_req_ready = 1'b0; kill = 1'b1;
    tick(); kill = 1'b0; in_valid = 1'b1; in_ctrl = 4'd4; in_addr = 64'h3001;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL kill_drain_%0d got %b %b exp 0 0", i, in_ready, out_valid); else passed++;
      tick();
    end
    dc_resp_valid = 1'b1; dc_rdata = 64'h0000_0000_0000_8000; #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL kill_resp_cycle got %b %b exp 0 0", in_ready, out_valid); else passed++;
    tick(); dc_resp_valid = 1'b0; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL kill_after_drain got %b %b exp 1 0", in_ready, out_valid); else passed++;
    tick(); in_valid = 1'b0; dc_req_ready = 1'b1; dc_resp_valid = 1'b1;
    tick(); dc_req_ready = 1'b0; dc_resp_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b1 || out_data !== 64'hFFFF_FFFF_FFFF_FF80 || out_exc !== 2'd0) $display("FAIL kill_next_op got %b %h %h exp 1 ffffffffffffff80 0", out_valid, out_data, out_exc); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_rst_wait();
    in_valid = 1'b1; in_ctrl = 4'd2; in_addr = 64'h4004;
    tick(); in_valid = 1'b0; dc_req_ready = 1'b1;
    tick(); dc_req_ready = 1'b0; rst = 1'b1;
    tick(); #1;
    total++; if (in_ready !== 1'b0 || dc_req_valid !== 1'b0 || out_valid !== 1'b0 || dc_addr !== 64'h0 || out_data !== 64'h0) $display("FAIL rst_wait_outputs got %b %b %b %h %h exp all 0", in_ready, dc_req_valid, out_valid, dc_addr, out_data); else passed++;
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1 || dc_addr !== 64'h0 || out_exc !== 2'd0) $display("FAIL rst_wait_cleared got %b %h %h exp 1 0 0", in_ready, dc_addr, out_exc); else passed++;
    dc_resp_valid = 1'b1; dc_rdata = 64'h1;
    tick(); dc_resp_valid = 1'b0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_stale_resp got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_xlen32();
    s_in_valid = 1'b1; s_in_ctrl = 4'd1; s_in_addr = 32'h0;
    tick(); s_in_valid = 1'b0; #1;
    total++; if (s_out_valid !== 1'b1 || s_out_exc !== 2'd3 || s_dc_req_valid !== 1'b0) $display("FAIL x32_ld got %b %h %b exp 1 3 0", s_out_valid, s_out_exc, s_dc_req_valid); else passed++;
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_ctrl = 4'd7; s_in_addr = 32'h2;
    tick(); s_in_valid = 1'b0; #1;
    total++; if (s_dc_req_valid !== 1'b1 || s_dc_addr !== 32'h0) $display("FAIL x32_lbu_req got %b %h exp 1 0", s_dc_req_valid, s_dc_addr); else passed++;
    s_dc_req_ready = 1'b1; s_dc_resp_valid = 1'b1; s_dc_rdata = 32'h00F1_0000;
    tick(); s_dc_req_ready = 1'b0; s_dc_resp_valid = 1'b0; #1;
    total++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h0000_00F1) $display("FAIL x32_lbu got %b %h exp 1 000000f1", s_out_valid, s_out_data); else passed++;
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_ctrl = 4'd10; s_in_addr = 32'h2; s_in_wdata = 32'h1234;
    tick(); s_in_valid = 1'b0; #1;
    total++; if (s_dc_wmask !== 4'hC || s_dc_wdata !== 32'h1234_0000) $display("FAIL x32_sh got %h %h exp c 12340000", s_dc_wmask, s_dc_wdata); else passed++;
    s_dc_req_ready = 1'b1; s_dc_resp_valid = 1'b1; tick(); s_dc_req_ready = 1'b0; s_dc_resp_valid = 1'b0;
    s_out_ready = 1'b1; tick(); s_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb();
    test_exceptions();
    test_stall();
    test_kill();
    test_rst_wait();
    test_xlen32();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
